// File: rtl/frost32_fetch_unit_pkg.sv
// Shared types and constants for the Frost32 instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frost32_fetch_unit_pkg;

    // Bus widths, mirrored from the core-wide definitions.
    localparam int unsigned AddrMsb = 31;
    localparam int unsigned DataMsb = 31;

    // Memory access encodings used on the instruction port.
    localparam logic       DiatRead = 1'b0;
    localparam logic [1:0] Dias32   = 2'b10;

    // Sequential fetch stride.
    localparam logic [AddrMsb:0] PcIncr = 32'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DataMsb:0] instr;
        logic [AddrMsb:0] pc;
    } FetchBufEntry;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [AddrMsb:0] word_align(input logic [AddrMsb:0] addr);
        return {addr[AddrMsb:2], 2'b00};
    endfunction

endpackage

// File: rtl/frost32_fetch_unit_if.sv
// Memory, redirect and decode-side signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: decode_ready stalls the head; mem_req is held until mem_ack.
interface frost32_fetch_unit_if;
    import frost32_fetch_unit_pkg::*;

    logic             mem_req;
    logic [AddrMsb:0] mem_addr;
    logic             mem_access_type;
    logic [1:0]       mem_access_size;
    logic             mem_ack;
    logic [DataMsb:0] mem_rdata;
    logic             redirect_en;
    logic [AddrMsb:0] redirect_pc;
    logic             instr_valid;
    logic [DataMsb:0] instr_data;
    logic [AddrMsb:0] instr_pc;
    logic             decode_ready;

    // Fetch unit side.
    modport master (
        output mem_req, mem_addr, mem_access_type, mem_access_size,
        output instr_valid, instr_data, instr_pc,
        input  mem_ack, mem_rdata, redirect_en, redirect_pc, decode_ready
    );

    // Memory / write-back / decode side.
    modport slave (
        input  mem_req, mem_addr, mem_access_type, mem_access_size,
        input  instr_valid, instr_data, instr_pc,
        output mem_ack, mem_rdata, redirect_en, redirect_pc, decode_ready
    );

endinterface

// File: rtl/frost32_fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
// Latency: push visible at head the cycle after; head is a register, no comb path from push data.
// Backpressure: caller must not push when full; pop when empty is ignored; flush wins over push.
module frost32_fetch_buffer
    import frost32_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  FetchBufEntry           i_push_dat,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_head_vld,
    output FetchBufEntry           o_head_dat
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    FetchBufEntry    r_mem [DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            w_do_pop;
    logic            w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_do_push = i_push && !i_flush;

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_head_vld = (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/frost32_fetch_unit.sv
// Frost32 fetch stage: owns the fetch PC, issues single-outstanding word reads, buffers words for decode.
// Latency: mem_ack at cycle N -> instr_valid at N+1; redirect at N -> new-PC request at N+1 when idle or acked.
// Backpressure: requests issue only while buffer slots remain (count + outstanding < BUF_DEPTH); decode_ready stalls the head.
module frost32_fetch_unit
    import frost32_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    frost32_fetch_unit_if.master bus
);

    localparam int unsigned     CntW     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(BUF_DEPTH);

    fetch_state_t     r_state;
    logic [AddrMsb:0] r_fetch_pc;
    logic [AddrMsb:0] r_mem_addr;
    logic             r_mem_req;

    logic [CntW-1:0]  w_count;
    logic [CntW-1:0]  w_count_after;
    logic             w_head_vld;
    FetchBufEntry     w_head_dat;
    FetchBufEntry     w_push_dat;
    logic             w_pop;
    logic             w_push;
    logic [AddrMsb:0] w_next_pc;
    logic [AddrMsb:0] w_redirect_tgt;

    assign w_pop          = w_head_vld && bus.decode_ready;
    assign w_push         = (r_state == StWait) && bus.mem_ack && !bus.redirect_en;
    assign w_push_dat     = '{instr: bus.mem_rdata, pc: r_mem_addr};
    // Occupancy once this cycle's ack push and decode pop have both landed.
    assign w_count_after  = w_count + CntW'(1) - CntW'(w_pop);
    assign w_next_pc      = r_fetch_pc + PcIncr;
    assign w_redirect_tgt = word_align(bus.redirect_pc);

    frost32_fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (bus.redirect_en),
        .o_count    (w_count),
        .o_head_vld (w_head_vld),
        .o_head_dat (w_head_dat)
    );

    // Request FSM: redirects override everything; a request on the bus is never retracted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_fetch_pc <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else if (bus.redirect_en) begin
            r_fetch_pc <= w_redirect_tgt;
            // Buffer is flushed this cycle, so a slot is always free for the target.
            if ((r_state == StIdle) || bus.mem_ack) begin
                r_state    <= StWait;
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_redirect_tgt;
            end else begin
                r_state <= StDrop;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_count < DepthCnt) begin
                        r_state    <= StWait;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                StWait: begin
                    if (bus.mem_ack) begin
                        r_fetch_pc <= w_next_pc;
                        if (w_count_after < DepthCnt) begin
                            r_mem_addr <= w_next_pc;
                        end else begin
                            r_mem_req <= 1'b0;
                            r_state   <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    // Stale word returns; go straight to the redirected PC (buffer is empty).
                    if (bus.mem_ack) begin
                        r_state    <= StWait;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req         = r_mem_req;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_access_type = DiatRead;
    assign bus.mem_access_size = Dias32;
    assign bus.instr_valid     = w_head_vld;
    assign bus.instr_data      = w_head_dat.instr;
    assign bus.instr_pc        = w_head_dat.pc;

endmodule

// File: tb/tb_frost32_fetch_unit.sv
// Bench for frost32_fetch_unit: directed scenarios plus an instruction-stream model checked every cycle.
// Latency: n/a.
// Backpressure: memory latency and decode_ready are driven by the scenarios.
module tb_frost32_fetch_unit;
    import frost32_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    frost32_fetch_unit_if bus_if ();

    frost32_fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ack_lat  = 1;

    // Contents of instruction memory at a given address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Memory responder plus stream model: decode must see PCs in program order, restarting at each redirect.
    initial begin : mem_and_model
        int          wcnt;
        logic [31:0] exp_pc;
        logic        exp_empty;
        logic        prev_stall;
        logic [31:0] prev_pc;
        logic [31:0] prev_dat;
        logic        prev_wait;
        logic [31:0] prev_addr;
        wcnt       = 0;
        exp_pc     = RST_PC;
        exp_empty  = 1'b0;
        prev_stall = 1'b0;
        prev_pc    = '0;
        prev_dat   = '0;
        prev_wait  = 1'b0;
        prev_addr  = '0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (bus_if.mem_req && !rst) begin
                wcnt++;
                if (wcnt >= ack_lat) begin
                    bus_if.mem_ack   = 1'b1;
                    bus_if.mem_rdata = mem_word(bus_if.mem_addr);
                    wcnt = 0;
                end else begin
                    bus_if.mem_ack   = 1'b0;
                    bus_if.mem_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                wcnt = 0;
                bus_if.mem_ack   = 1'b0;
                bus_if.mem_rdata = 32'hDEAD_BEEF;
            end

            if (rst) begin
                exp_pc     = RST_PC;
                exp_empty  = 1'b0;
                prev_stall = 1'b0;
                prev_wait  = 1'b0;
            end else begin
                if (exp_empty) begin
                    chk("m_flush_empty", 32'(bus_if.instr_valid), 32'd0);
                end
                if (prev_stall) begin
                    chk("m_stall_valid", 32'(bus_if.instr_valid), 32'd1);
                    chk("m_stall_pc", bus_if.instr_pc, prev_pc);
                    chk("m_stall_data", bus_if.instr_data, prev_dat);
                end
                if (prev_wait) begin
                    chk("m_hold_req", 32'(bus_if.mem_req), 32'd1);
                    chk("m_hold_addr", bus_if.mem_addr, prev_addr);
                end
                if (bus_if.mem_req) begin
                    chk("m_acc_type", 32'(bus_if.mem_access_type), 32'(DiatRead));
                    chk("m_acc_size", 32'(bus_if.mem_access_size), 32'(Dias32));
                end
                if (bus_if.instr_valid && bus_if.decode_ready) begin
                    chk("m_deliver_pc", bus_if.instr_pc, exp_pc);
                    chk("m_deliver_data", bus_if.instr_data, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
                exp_empty = bus_if.redirect_en;
                if (bus_if.redirect_en) begin
                    exp_pc = bus_if.redirect_pc & ~32'h3;
                end
                prev_stall = bus_if.instr_valid && !bus_if.decode_ready && !bus_if.redirect_en;
                prev_pc    = bus_if.instr_pc;
                prev_dat   = bus_if.instr_data;
                prev_wait  = bus_if.mem_req && !bus_if.mem_ack;
                prev_addr  = bus_if.mem_addr;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus_if.decode_ready = 1'b0;
        bus_if.redirect_en  = 1'b0;
        bus_if.redirect_pc  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus_if.mem_req), 32'd0);
        chk("rst_addr", bus_if.mem_addr, 32'd0);
        chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("rst_data", bus_if.instr_data, 32'd0);
        chk("rst_pc", bus_if.instr_pc, 32'd0);
        chk("rst_type", 32'(bus_if.mem_access_type), 32'd0);
        chk("rst_size", 32'(bus_if.mem_access_size), 32'd2);

        // Streaming, 1-cycle memory, decode always ready.
        nxt(); rst = 1'b0; bus_if.decode_ready = 1'b1;
        nxt(); @(negedge clk);
        chk("first_req", 32'(bus_if.mem_req), 32'd1);
        chk("first_addr", bus_if.mem_addr, 32'h100);
        nxt(); @(negedge clk);
        chk("first_valid", 32'(bus_if.instr_valid), 32'd1);
        chk("first_pc", bus_if.instr_pc, 32'h100);
        chk("first_data", bus_if.instr_data, mem_word(32'h100));
        for (int i = 1; i <= 6; i++) begin
            nxt(); @(negedge clk);
            chk("stream_valid", 32'(bus_if.instr_valid), 32'd1);
            chk("stream_pc", bus_if.instr_pc, 32'h100 + 32'(4 * i));
        end

        // Decode stalls 10 cycles: two words buffered (0x11c, 0x120), then fetch stops.
        nxt(); bus_if.decode_ready = 1'b0;
        repeat (9) nxt();
        @(negedge clk);
        chk("stall_req", 32'(bus_if.mem_req), 32'd0);
        chk("stall_valid", 32'(bus_if.instr_valid), 32'd1);
        chk("stall_pc", bus_if.instr_pc, 32'h11c);
        nxt(); bus_if.decode_ready = 1'b1;
        @(negedge clk);
        chk("rel0_pc", bus_if.instr_pc, 32'h11c);
        chk("rel0_req", 32'(bus_if.mem_req), 32'd0);
        nxt(); @(negedge clk);
        chk("rel1_pc", bus_if.instr_pc, 32'h120);
        chk("rel1_req", 32'(bus_if.mem_req), 32'd0);
        nxt(); @(negedge clk);
        chk("rel2_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("rel2_req", 32'(bus_if.mem_req), 32'd1);
        chk("rel2_addr", bus_if.mem_addr, 32'h124);

        // Redirect to 0x2002 while 0x128 is outstanding with slow memory.
        nxt(); ack_lat = 4;
        @(negedge clk);
        chk("rel3_pc", bus_if.instr_pc, 32'h124);
        chk("slow_addr", bus_if.mem_addr, 32'h128);
        nxt(); bus_if.redirect_en = 1'b1; bus_if.redirect_pc = 32'h0000_2002;
        @(negedge clk);
        chk("redir_addr", bus_if.mem_addr, 32'h128);
        nxt(); bus_if.redirect_en = 1'b0;
        @(negedge clk);
        chk("drop_req", 32'(bus_if.mem_req), 32'd1);
        chk("drop_addr", bus_if.mem_addr, 32'h128);
        nxt(); ack_lat = 1;
        @(negedge clk);
        chk("drop_ack_addr", bus_if.mem_addr, 32'h128);
        nxt(); @(negedge clk);
        chk("tgt_addr", bus_if.mem_addr, 32'h2000);
        chk("tgt_no_stale", 32'(bus_if.instr_valid), 32'd0);

        // Redirect coinciding with an ack and a decode pop.
        nxt(); bus_if.redirect_en = 1'b1; bus_if.redirect_pc = 32'h0000_3000;
        @(negedge clk);
        chk("tgt_pc", bus_if.instr_pc, 32'h2000);
        chk("tgt_data", bus_if.instr_data, mem_word(32'h2000));
        chk("coin_addr", bus_if.mem_addr, 32'h2004);
        nxt(); bus_if.redirect_en = 1'b0;
        @(negedge clk);
        chk("coin_empty", 32'(bus_if.instr_valid), 32'd0);
        chk("coin_req", 32'(bus_if.mem_req), 32'd1);
        chk("coin_new_addr", bus_if.mem_addr, 32'h3000);

        // Wrap of the fetch PC past the top of the address space.
        nxt(); bus_if.redirect_en = 1'b1; bus_if.redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        chk("coin_pc", bus_if.instr_pc, 32'h3000);
        nxt(); bus_if.redirect_en = 1'b0;
        @(negedge clk);
        chk("wrap_a0", bus_if.mem_addr, 32'hFFFF_FFF8);
        nxt(); @(negedge clk);
        chk("wrap_a1", bus_if.mem_addr, 32'hFFFF_FFFC);
        chk("wrap_p0", bus_if.instr_pc, 32'hFFFF_FFF8);
        nxt(); @(negedge clk);
        chk("wrap_a2", bus_if.mem_addr, 32'h0000_0000);
        chk("wrap_p1", bus_if.instr_pc, 32'hFFFF_FFFC);
        nxt(); ack_lat = 5; bus_if.decode_ready = 1'b0;
        @(negedge clk);
        chk("wrap_p2", bus_if.instr_pc, 32'h0000_0000);
        chk("wrap_a3", bus_if.mem_addr, 32'h0000_0004);

        // Reset while a request is pending and the buffer holds a word.
        nxt();
        chk("pre_rst_req", 32'(bus_if.mem_req), 32'd1);
        chk("pre_rst_valid", 32'(bus_if.instr_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus_if.mem_req), 32'd0);
        chk("mid_rst_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("mid_rst_pc", bus_if.instr_pc, 32'd0);
        nxt(); nxt();
        rst = 1'b0; bus_if.decode_ready = 1'b1; ack_lat = 1;
        nxt(); @(negedge clk);
        chk("post_rst_req", 32'(bus_if.mem_req), 32'd1);
        chk("post_rst_addr", bus_if.mem_addr, RST_PC);
        nxt(); @(negedge clk);
        chk("post_rst_pc", bus_if.instr_pc, RST_PC);
        chk("post_rst_data", bus_if.instr_data, mem_word(RST_PC));
        repeat (4) nxt();
        @(negedge clk);
        chk("post_rst_stream", bus_if.instr_pc, RST_PC + 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
